// File: rtl/song_pkg.sv
// ----------------------------------------------------------------------------
// song_pkg
// Shared types and defaults for the song playback engine.
//   note_idx_t   : ROM address type (DEFAULT_IDX_W bits)
//   note_dur_t   : note duration in clock cycles (DEFAULT_DUR_W bits)
//   seq_state_e  : playback FSM states
// Optional feature macro used by the sequencer: SONG_SEQ_LOOP_EN
// ----------------------------------------------------------------------------
package song_pkg;

   localparam int DEFAULT_IDX_W = 11;
   localparam int DEFAULT_DUR_W = 29;

   typedef logic [DEFAULT_IDX_W-1:0] note_idx_t;
   typedef logic [DEFAULT_DUR_W-1:0] note_dur_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      PLAY   = 3'd2,
      PAUSED = 3'd3,
      FIN    = 3'd4
   } seq_state_e;

endpackage

// File: rtl/song_sequencer_dur_countdown.sv
// ----------------------------------------------------------------------------
// dur_countdown
// Loadable unsigned down-counter holding the remaining cycles of a note.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val (has priority over en)
//   en         : decrement by one; count holds while low
//   load_val   : value to load
//   count      : current count
//   last       : high when count == 1 (final cycle of the note)
// ----------------------------------------------------------------------------
module dur_countdown
   import song_pkg::*;
#(
   parameter int DUR_W = DEFAULT_DUR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [DUR_W-1:0] load_val,
   output logic [DUR_W-1:0] count,
   output logic             last
);

   logic [DUR_W-1:0] count_r;

   // Count register: load wins over decrement, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {DUR_W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (en) begin
         count_r <= count_r - {{(DUR_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign last  = (count_r == {{(DUR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/song_sequencer.sv
// ----------------------------------------------------------------------------
// song_sequencer
// Walks a song's note-duration ROM from index 0 upward, holding each note for
// exactly note_dur cycles (one LOAD cycle plus note_dur-1 PLAY cycles).
// A zero duration or reaching SONG_LEN notes ends the song.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin playback from index 0 (only honoured in IDLE)
//   stop        : abort to IDLE, no done pulse; beats start
//   pause       : freeze the current note while high (PLAY only)
//   note_dur    : combinational ROM data for note_index
//   note_index  : ROM address
//   note_active : note sounding (LOAD with nonzero duration, or PLAY)
//   note_strobe : first cycle of each note
//   busy        : any state except IDLE
//   done        : one-cycle pulse at natural end of song
// Macro SONG_SEQ_LOOP_EN: when defined, end of song pulses done and restarts
// at index 0 directly in LOAD instead of returning to IDLE.
// ----------------------------------------------------------------------------
module song_sequencer
   import song_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int IDX_W      = DEFAULT_IDX_W,
   parameter int DUR_W      = DEFAULT_DUR_W,
   parameter int SONG_LEN   = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [DUR_W-1:0] note_dur,
   output logic [IDX_W-1:0] note_index,
   output logic             note_active,
   output logic             note_strobe,
   output logic             busy,
   output logic             done
);

   // Reject parameter sets the index register cannot represent.
   if (CLOCK_FREQ < 1 || SONG_LEN < 1 || SONG_LEN > (1 << IDX_W)) begin : g_param_check
      $error("song_sequencer: bad CLOCK_FREQ/SONG_LEN/IDX_W combination");
   end

   // One bit wider than the index so SONG_LEN itself is representable.
   localparam logic [IDX_W:0] LEN_C = (IDX_W+1)'(SONG_LEN);

   seq_state_e       state_r, state_nxt_s;
   logic [IDX_W-1:0] index_r, index_nxt_s;
   logic [IDX_W:0]   idx_plus1_s;
   logic             at_end_s;
   logic             end_song_s;
   logic             dur_zero_s;
   logic             dur_one_s;
   logic             cnt_load_s;
   logic             cnt_en_s;
   logic             cnt_last_s;
   logic             done_s;
   logic [DUR_W-1:0] cnt_count_s;

   assign idx_plus1_s = {1'b0, index_r} + {{IDX_W{1'b0}}, 1'b1};
   assign at_end_s    = (idx_plus1_s == LEN_C);
   assign dur_zero_s  = (note_dur == {DUR_W{1'b0}});
   assign dur_one_s   = (note_dur == {{(DUR_W-1){1'b0}}, 1'b1});

   dur_countdown #(
      .DUR_W (DUR_W)
   ) u_dur_countdown (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load_s),
      .en       (cnt_en_s),
      .load_val (note_dur - {{(DUR_W-1){1'b0}}, 1'b1}),
      .count    (cnt_count_s),
      .last     (cnt_last_s)
   );

   // State and index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         index_r <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         index_r <= index_nxt_s;
      end
   end

   // Next-state, index and counter control; stop overrides everything.
   always_comb begin
      state_nxt_s = state_r;
      index_nxt_s = index_r;
      end_song_s  = 1'b0;
      cnt_load_s  = 1'b0;
      cnt_en_s    = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            index_nxt_s = {IDX_W{1'b0}};
            if (start) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            if (dur_zero_s) begin
               end_song_s = 1'b1;
            end else if (dur_one_s) begin
               // Single-cycle note: the LOAD cycle is the whole note.
               if (at_end_s) begin
                  end_song_s = 1'b1;
               end else begin
                  index_nxt_s = idx_plus1_s[IDX_W-1:0];
                  state_nxt_s = LOAD;
               end
            end else begin
               cnt_load_s  = 1'b1;
               state_nxt_s = PLAY;
            end
         end
         PLAY: begin
            // Every PLAY cycle is a sounding cycle, so it always counts; the
            // final cycle advances even if pause arrives on it.
            cnt_en_s = 1'b1;
            if (cnt_last_s) begin
               if (at_end_s) begin
                  end_song_s = 1'b1;
               end else begin
                  index_nxt_s = idx_plus1_s[IDX_W-1:0];
                  state_nxt_s = LOAD;
               end
            end else if (pause) begin
               state_nxt_s = PAUSED;
            end else begin
               state_nxt_s = PLAY;
            end
         end
         PAUSED: begin
            if (pause) begin
               state_nxt_s = PAUSED;
            end else begin
               state_nxt_s = PLAY;
            end
         end
         FIN: begin
            done_s      = 1'b1;
            index_nxt_s = {IDX_W{1'b0}};
            state_nxt_s = IDLE;
         end
         default: begin
            index_nxt_s = {IDX_W{1'b0}};
            state_nxt_s = IDLE;
         end
      endcase

      if (end_song_s) begin
`ifdef SONG_SEQ_LOOP_EN
         done_s      = 1'b1;
         index_nxt_s = {IDX_W{1'b0}};
         state_nxt_s = LOAD;
`else
         state_nxt_s = FIN;
`endif
      end else begin
         state_nxt_s = state_nxt_s;
      end

      if (stop) begin
         state_nxt_s = IDLE;
         index_nxt_s = {IDX_W{1'b0}};
         cnt_load_s  = 1'b0;
         cnt_en_s    = 1'b0;
         done_s      = 1'b0;
      end else begin
         done_s = done_s;
      end
   end

   assign note_index  = index_r;
   assign note_strobe = (state_r == LOAD) && !dur_zero_s;
   assign note_active = ((state_r == LOAD) && !dur_zero_s) || (state_r == PLAY);
   assign busy        = (state_r != IDLE);
   assign done        = done_s;

endmodule
